// File: rtl/sync_fifo_core_if.sv
// Purpose: write/read handshake and status bundle for sync_fifo_core.
// Signals:
//   i_wen/i_wdata  write request and data         (master -> fifo)
//   i_ren          read request                   (master -> fifo)
//   o_rdata/o_rvalid registered read data + valid (fifo -> master)
//   o_empty/o_full/o_afull/o_count  occupancy     (fifo -> master)
//   o_wr_err/o_rd_err  rejected-request pulses    (fifo -> master)
interface sync_fifo_core_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              i_wen;
    logic [DATA_W-1:0] i_wdata;
    logic              i_ren;
    logic [DATA_W-1:0] o_rdata;
    logic              o_rvalid;
    logic              o_empty;
    logic              o_full;
    logic              o_afull;
    logic [ADDR_W:0]   o_count;
    logic              o_wr_err;
    logic              o_rd_err;

    modport master (
        output i_wen, i_wdata, i_ren,
        input  o_rdata, o_rvalid, o_empty, o_full, o_afull, o_count,
               o_wr_err, o_rd_err
    );

    modport slave (
        input  i_wen, i_wdata, i_ren,
        output o_rdata, o_rvalid, o_empty, o_full, o_afull, o_count,
               o_wr_err, o_rd_err
    );
endinterface

// File: rtl/sync_fifo_core.sv
// Purpose: single-clock FIFO, 2**ADDR_W x DATA_W register storage, wrap-bit
//          pointers, registered status flags and one-cycle error pulses.
// Ports:
//   i_clk   clock, all state updates on rising edge
//   i_rest  asynchronous active-low reset
//   bus     sync_fifo_core_if slave: write/read handshake and status
module sync_fifo_core #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic             i_clk,
    input  logic             i_rest,
    sync_fifo_core_if.slave  bus
);
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_afull;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_wr_err;
    logic              r_rd_err;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [PTR_W-1:0]  w_wptr_nxt;
    logic [PTR_W-1:0]  w_rptr_nxt;
    logic [PTR_W-1:0]  w_count_nxt;

    // Acceptance is judged on the registered (pre-edge) flags.
    assign w_wr_acc    = bus.i_wen & ~r_full;
    assign w_rd_acc    = bus.i_ren & ~r_empty;
    assign w_wptr_nxt  = r_wptr + PTR_W'(w_wr_acc);
    assign w_rptr_nxt  = r_rptr + PTR_W'(w_rd_acc);
    assign w_count_nxt = r_count + PTR_W'(w_wr_acc) - PTR_W'(w_rd_acc);

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= bus.i_wdata;
        end
    end

    // Pointers, occupancy and flags; flags derive from next-state pointers
    // so they are valid the cycle after the causing edge.
    always_ff @(posedge i_clk or negedge i_rest) begin
        if (!i_rest) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_count  <= w_count_nxt;
            r_empty  <= (w_wptr_nxt == w_rptr_nxt);
            r_full   <= (w_wptr_nxt == {~w_rptr_nxt[ADDR_W], w_rptr_nxt[ADDR_W-1:0]});
            r_afull  <= (w_count_nxt >= PTR_W'(AF_LEVEL));
            r_rvalid <= w_rd_acc;
            r_wr_err <= bus.i_wen & r_full;
            r_rd_err <= bus.i_ren & r_empty;
            if (w_rd_acc) begin
                r_rdata <= r_mem[r_rptr[ADDR_W-1:0]];
            end
        end
    end

    assign bus.o_rdata  = r_rdata;
    assign bus.o_rvalid = r_rvalid;
    assign bus.o_empty  = r_empty;
    assign bus.o_full   = r_full;
    assign bus.o_afull  = r_afull;
    assign bus.o_count  = r_count;
    assign bus.o_wr_err = r_wr_err;
    assign bus.o_rd_err = r_rd_err;
endmodule
